serial_feeder: RTL and testbench
================================

# serial_feeder

Parallel-to-serial front end for the bit-serial pattern detector. Accepts WIDTH-bit words over a valid/ready handshake, holds one word in a skid register, and shifts each word out MSB-first on a single-bit data line with a qualifying enable. Outputs are registered on the rising edge of clk, so they are stable when the downstream detector samples on the falling edge.

## Interface
- WIDTH, 8: word width in bits, 2..32.
- GAP, 0: idle cycles between words with en low, 0..15.

- clk  input  1: single clock; all registers update on the rising edge.
- reset  input  1: asynchronous, active-high; clears all state.
- in_data  input  WIDTH: word to serialise.
- in_valid  input  1: in_data valid this cycle.
- in_ready  output  1: hold register empty; a word transfers on the rising edge where in_valid && in_ready.
- dout  output  1: serial bit, registered.
- en  output  1: dout qualifier, registered; high only while a data or parity bit is presented.
- busy  output  1: state != IDLE or hold register full.
- word_cnt  output  8: words fully transmitted, wraps 255 -> 0.

## Operation
- Storage: one hold register (hold_data, hold_full), WIDTH-bit shift register, bit counter of clog2(WIDTH) bits, gap counter of 4 bits.
- in_ready = !hold_full, with no combinational path from in_valid.
- Accept and drain on the same edge: hold_full remains 1 with the new word; the old word moves to the shifter.
- FSM states:
  - IDLE: en=0, dout=0. If hold_full, load the shifter from hold, clear hold_full, set bitcnt = WIDTH-1, go to SHIFT.
  - SHIFT: en=1, dout = shifter MSB. Shift left one bit per cycle. At bitcnt==0, go to PAR if SER_PARITY_EN is defined, else go to END.
  - PAR: en=1, dout = XOR of the word, giving even parity. Then go to END.
  - END: this is the transition logic only, not a cycle. Increment word_cnt. If GAP>0, go to GAP with gapcnt=GAP-1. Else if hold_full, reload and stay in SHIFT with no bubble. Else go to IDLE.
  - GAP: en=0, dout=0 for exactly GAP cycles, then behave as IDLE on the following edge.
- word_cnt increments on the edge that retires the last presented bit of a word.
- With GAP=0 and a continuous input stream, en stays high with no gaps.
- dout is forced to 0 whenever en=0.

## Timing
- Reset values: dout=0, en=0, in_ready=1, busy=0, word_cnt=0. The FSM is in IDLE and the hold register is empty.
- Reset assertion drops en and dout immediately, without waiting for a clock edge.
- Reset mid-word discards both the in-flight word and the held word. After release, the next accepted word starts from its MSB.
- Latency: a word accepted at edge N has its MSB on dout with en=1 after edge N+1, when the FSM is idle.
- Word duration: WIDTH cycles of en=1, or WIDTH+1 cycles with parity enabled. This is followed by GAP cycles of en=0.
- Throughput with GAP=0: one word per WIDTH (or WIDTH+1) cycles, sustained.
- Backpressure: in_ready stays low from acceptance until the edge that loads the shifter.
- in_data is sampled only on the accepting edge. Later changes to in_data are ignored.

## Configuration
- SER_PARITY_EN defined: each word is followed by one even-parity bit with en=1. The PAR state exists, and word_cnt increments after the parity bit.
- SER_PARITY_EN undefined: the PAR state and parity logic are absent, and a word occupies exactly WIDTH en-cycles.

## Test plan
- Reset: assert reset with in_valid=1. Required: dout=0, en=0, in_ready=1, busy=0, word_cnt=0 throughout. No word is accepted.
- Single word: WIDTH=8, GAP=0, 8'hA5 accepted at edge N. Required: en=1 for edges N+1..N+8, dout sequence 1,0,1,0,0,1,0,1, then en=0 and word_cnt=1.
- Back-to-back: 8'hFF, 8'h00 and 8'hFF with in_valid held high. Required: 24 contiguous en=1 cycles with pattern 8 ones, 8 zeros, 8 ones. in_ready pulses low per word, and word_cnt=3.
- Gap: GAP=3, two words. Required: exactly 3 cycles of en=0, dout=0 between the last bit of word 1 and the MSB of word 2.
- Mid-word reset: assert reset asynchronously during the 4th bit of 8'hC3. Required: en=0 at once, word_cnt unchanged at 0. 8'h81 sent after release produces 1,0,0,0,0,0,0,1.
- Parity (SER_PARITY_EN): 8'h07 gives a 9th bit of 1, and 8'h03 gives a 9th bit of 0, each with en=1. After 256 words, word_cnt wraps to 0.

Source files
------------

// File: rtl/serial_feeder.sv
// Parallel-to-serial front end: one-word skid register feeding an MSB-first shifter.
// Define SER_PARITY_EN to append an even-parity bit (with en=1) after every word.
module serial_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             en,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAR, ST_GAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic [WIDTH-1:0] shifter, shifter_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [3:0]       gapcnt, gapcnt_n;
  logic [7:0]       cnt_n;
  logic             dout_n, en_n;
  logic             load, retire;
`ifdef SER_PARITY_EN
  logic             par_bit, par_n;
`endif

  assign in_ready = !hold_full;
  assign busy     = (state != ST_IDLE) || hold_full;

  // Next-state logic; "retire" is the END transition, folded into the edge
  // that retires the last presented bit of a word.
  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    bitcnt_n  = bitcnt;
    gapcnt_n  = gapcnt;
    cnt_n     = word_cnt;
    load      = 1'b0;
    retire    = 1'b0;
    dout_n    = 1'b0;
    en_n      = 1'b0;
`ifdef SER_PARITY_EN
    par_n     = par_bit;
`endif

    case (state)
      ST_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      ST_SHIFT: begin
        if (bitcnt != '0) begin
          shifter_n = shifter << 1;
          bitcnt_n  = bitcnt - 1'b1;
        end else begin
`ifdef SER_PARITY_EN
          state_n = ST_PAR;
`else
          retire  = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        retire = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gapcnt != 4'd0)  gapcnt_n = gapcnt - 4'd1;
        else if (hold_full)  load     = 1'b1;
        else                 state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (retire) begin
      cnt_n = word_cnt + 8'd1;
      if (GAP > 0) begin
        state_n  = ST_GAP;
        gapcnt_n = 4'(GAP - 1);
      end else if (hold_full) begin
        load = 1'b1;
      end else begin
        state_n = ST_IDLE;
      end
    end

    if (load) begin
      shifter_n = hold_data;
      bitcnt_n  = BW'(WIDTH - 1);
      state_n   = ST_SHIFT;
`ifdef SER_PARITY_EN
      par_n     = ^hold_data;
`endif
    end

    // Outputs are registered from the next state so they lead the falling-edge sampler.
    if (state_n == ST_SHIFT) begin
      en_n   = 1'b1;
      dout_n = shifter_n[WIDTH-1];
    end
`ifdef SER_PARITY_EN
    if (state_n == ST_PAR) begin
      en_n   = 1'b1;
      dout_n = par_n;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shifter   <= '0;
      bitcnt    <= '0;
      gapcnt    <= 4'd0;
      word_cnt  <= 8'd0;
      dout      <= 1'b0;
      en        <= 1'b0;
`ifdef SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shifter   <= shifter_n;
      bitcnt    <= bitcnt_n;
      gapcnt    <= gapcnt_n;
      word_cnt  <= cnt_n;
      dout      <= dout_n;
      en        <= en_n;
`ifdef SER_PARITY_EN
      par_bit   <= par_n;
`endif
    end
  end

  // Skid register: a new accept takes priority over the drain into the shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_data <= in_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Self-checking bench for serial_feeder: a GAP=0 instance and a GAP=3 instance.
// Parity expectations follow SER_PARITY_EN.
module tb_serial_feeder;

`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 8 + PB;

  logic       clk, reset;
  logic [7:0] in_data;
  logic       in_valid, in_valid_g;
  logic       in_ready, dout, en, busy;
  logic [7:0] word_cnt;
  logic       in_ready_g, dout_g, en_g, busy_g;
  logic [7:0] word_cnt_g;

  serial_feeder #(.WIDTH(8), .GAP(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .en(en), .busy(busy), .word_cnt(word_cnt)
  );

  serial_feeder #(.WIDTH(8), .GAP(3)) dut_g (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid_g),
    .in_ready(in_ready_g), .dout(dout_g), .en(en_g), .busy(busy_g), .word_cnt(word_cnt_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic [8:0] bits;
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [7:0] words_q[$];
  logic cap_en[$], cap_dout[$];
  logic exp_en_q[$], exp_dout_q[$];
  int ready_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One word into an idle GAP=0 instance; in_data is scrambled after acceptance.
  task automatic apply_stimulus(input logic [7:0] w, input logic [8:0] bits, input logic [7:0] cnt_after);
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~w;
    check("ready_low_after_accept", in_ready, 1'b0);
    check("en_before_first_bit", en, 1'b0);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check($sformatf("en_bit%0d", i), en, 1'b1);
      check($sformatf("dout_bit%0d", i), dout, bits[8-i]);
    end
    @(negedge clk);
    check("en_after_word", en, 1'b0);
    check("dout_after_word", dout, 1'b0);
    check("word_cnt_after_word", word_cnt, cnt_after);
    check("busy_after_word", busy, 1'b0);
  endtask

  // Streams words_q through one instance with in_valid held high, capturing en/dout.
  task automatic run_stream(input bit use_gap, input int cycles);
    int idx = 0;
    bit acc = 1'b0;
    logic rdy, prev_rdy;
    prev_rdy = 1'b1;
    ready_drops = 0;
    cap_en.delete();
    cap_dout.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (acc) idx++;
      cap_en.push_back(use_gap ? en_g : en);
      cap_dout.push_back(use_gap ? dout_g : dout);
      rdy = use_gap ? in_ready_g : in_ready;
      if (prev_rdy && !rdy) ready_drops++;
      prev_rdy = rdy;
      in_data = (idx < words_q.size()) ? words_q[idx] : 8'h5A;
      if (use_gap) in_valid_g = (idx < words_q.size());
      else         in_valid   = (idx < words_q.size());
      acc = (idx < words_q.size()) && rdy;
    end
    in_valid   = 1'b0;
    in_valid_g = 1'b0;
  endtask

  // Expected stream: each word MSB-first (plus parity), followed by gap idle cycles.
  task automatic check_output(input int gap, input string tag);
    int f = -1;
    exp_en_q.delete();
    exp_dout_q.delete();
    foreach (words_q[k]) begin
      for (int b = 7; b >= 0; b--) begin
        exp_en_q.push_back(1'b1);
        exp_dout_q.push_back(words_q[k][b]);
      end
      if (PB == 1) begin
        exp_en_q.push_back(1'b1);
        exp_dout_q.push_back(^words_q[k]);
      end
      for (int g = 0; g < gap; g++) begin
        exp_en_q.push_back(1'b0);
        exp_dout_q.push_back(1'b0);
      end
    end
    for (int i = 0; i < cap_en.size(); i++)
      if (f < 0 && cap_en[i] === 1'b1) f = i;
    if (f < 0) begin
      check({tag, "_start_found"}, 1'b0, 1'b1);
      return;
    end
    for (int i = 0; i < exp_en_q.size(); i++) begin
      if (f + i >= cap_en.size()) begin
        check({tag, "_stream_length"}, f + i, cap_en.size());
        return;
      end
      check($sformatf("%s_en%0d", tag, i), cap_en[f+i], exp_en_q[i]);
      check($sformatf("%s_dout%0d", tag, i), cap_dout[f+i], exp_dout_q[i]);
    end
    if (f + exp_en_q.size() < cap_en.size())
      check({tag, "_en_after_stream"}, cap_en[f+exp_en_q.size()], 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t table_v[6];
    int ones;
    table_v[0] = '{8'hA5, 9'b1010_0101_0};
    table_v[1] = '{8'h07, 9'b0000_0111_1};
    table_v[2] = '{8'h03, 9'b0000_0011_0};
    table_v[3] = '{8'h80, 9'b1000_0000_1};
    table_v[4] = '{8'h3C, 9'b0011_1100_0};
    table_v[5] = '{8'hFE, 9'b1111_1110_1};

    reset      = 1'b1;
    in_data    = 8'hA5;
    in_valid   = 1'b1;
    in_valid_g = 1'b1;

    // Reset held with in_valid high: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dout", dout, 1'b0);
      check("rst_en", en, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_word_cnt", word_cnt, 8'd0);
    end
    in_valid   = 1'b0;
    in_valid_g = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 6; i++)
      apply_stimulus(table_v[i].word, table_v[i].bits, 8'(i + 1));

    // Back-to-back FF, 00, FF: contiguous en, one in_ready drop per word.
    do_reset();
    words_q = '{8'hFF, 8'h00, 8'hFF};
    run_stream(1'b0, 40);
    check_output(0, "b2b");
    ones = 0;
    foreach (cap_en[i]) if (cap_en[i] === 1'b1) ones++;
    check("b2b_en_cycles", ones, 3 * NB);
    check("b2b_ready_drops", ready_drops, 3);
    check("b2b_word_cnt", word_cnt, 8'd3);

    // GAP=3 instance: exactly three idle cycles between words.
    do_reset();
    words_q = '{8'hA5, 8'h3C};
    run_stream(1'b1, 40);
    check_output(3, "gap");
    check("gap_word_cnt", word_cnt_g, 8'd2);

    // Asynchronous reset during the 4th bit of C3.
    do_reset();
    @(negedge clk);
    in_data  = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("midrst_en_before", en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_en", en, 1'b0);
    check("midrst_dout", dout, 1'b0);
    check("midrst_word_cnt", word_cnt, 8'd0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(8'h81, 9'b1000_0001_0, 8'd1);

    // 256 back-to-back words wrap word_cnt to zero.
    do_reset();
    words_q.delete();
    for (int i = 0; i < 256; i++) words_q.push_back(8'(i));
    run_stream(1'b0, 256 * NB + 20);
    ones = 0;
    foreach (cap_en[i]) if (cap_en[i] === 1'b1) ones++;
    check("wrap_en_cycles", ones, 256 * NB);
    check("wrap_word_cnt", word_cnt, 8'd0);
    check("wrap_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
